bus_slave_mem: RTL

- Parametrised serial-bus memory slave; next generation of the fixed 4K serial slave.
- Receives a serial address and a direction bit from the bus master. Acknowledges on device-ID and range match, or NACKs. Then writes or reads one DATA_W-bit word serially.
- Memory depth, data width, address width, device ID and acknowledge length are all configurable.
- Sits on the shared serial bus beside other slaves, which are distinguished by DEV_ID.

---
 rtl/bus_slave_mem_if.sv | 35 +++
 rtl/bus_slave_mem.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/bus_slave_mem_if.sv
// rtl/bus_slave_mem_if.sv - serial bus signals between bus master and memory slave
interface bus_slave_mem_if #(
    parameter int DATA_W = 8
);
    logic              AD_SEL;
    logic              B_RW;
    logic              B_BUS_OUT;
    logic              B_BUS_IN;
    logic              B_ACK;
    logic              B_SBSY;
    logic              S_DVALID;
    logic [DATA_W-1:0] S_DOUT;

    modport master (
        output AD_SEL,
        output B_RW,
        output B_BUS_OUT,
        input  B_BUS_IN,
        input  B_ACK,
        input  B_SBSY,
        input  S_DVALID,
        input  S_DOUT
    );

    modport slave (
        input  AD_SEL,
        input  B_RW,
        input  B_BUS_OUT,
        output B_BUS_IN,
        output B_ACK,
        output B_SBSY,
        output S_DVALID,
        output S_DOUT
    );
endinterface

// File: rtl/bus_slave_mem.sv
// rtl/bus_slave_mem.sv - parametrised serial-bus memory slave with ID/range decode
module bus_slave_mem #(
    parameter int DATA_W   = 8,
    parameter int MEM_AW   = 12,
    parameter int BUS_AW   = 16,
    parameter int DEV_ID_W = 2,
    parameter int DEV_ID   = 0,
    parameter int ACK_CYC  = 2
) (
    input  logic           CLK,
    input  logic           RSTN,
    bus_slave_mem_if.slave bus
);

    // One counter serves every phase, so it must hold the longest phase length
    // plus the extra trailing cycle of the read phase.
    localparam int CNT_MAX_AD = (BUS_AW > DATA_W) ? BUS_AW : DATA_W;
    localparam int CNT_MAX    = (CNT_MAX_AD > ACK_CYC) ? CNT_MAX_AD : ACK_CYC;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int GAP_W      = BUS_AW - DEV_ID_W - MEM_AW;

    localparam logic [CNT_W-1:0]    ADDR_LAST  = CNT_W'(BUS_AW - 1);
    localparam logic [CNT_W-1:0]    ACK_LAST   = CNT_W'(ACK_CYC - 1);
    localparam logic [CNT_W-1:0]    WDATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0]    RDATA_LAST = CNT_W'(DATA_W);
    localparam logic [DEV_ID_W-1:0] DEV_ID_V   = DEV_ID_W'(DEV_ID);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ADDR,
        ST_AACK,
        ST_NACK,
        ST_WDATA,
        ST_WACK,
        ST_RDATA
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [BUS_AW-1:0]   addr_q, addr_d;
    logic                rw_q, rw_d;
    logic [DATA_W-1:0]   shreg_q, shreg_d;
    logic                bus_in_q, bus_in_d;
    logic                ack_q, ack_d;
    logic                sbsy_q, sbsy_d;
    logic                dvalid_q, dvalid_d;
    logic [DATA_W-1:0]   dout_q, dout_d;

    logic                mem_we;
    logic                rd_en;
    logic [DATA_W-1:0]   rd_q;
    logic [DATA_W-1:0]   mem [2**MEM_AW];

    logic [BUS_AW-1:0]   addr_shift;
    logic                id_ok;
    logic                range_ok;
    logic                match;
    logic [MEM_AW-1:0]   word_idx;

    // Address arrives LSB first; shifting right lands bit 0 at the LSB after
    // BUS_AW samples, and addr_shift is the complete address on the last edge.
    assign addr_shift = {bus.B_BUS_OUT, addr_q[BUS_AW-1:1]};
    assign id_ok      = (addr_shift[BUS_AW-1 -: DEV_ID_W] == DEV_ID_V);
    assign word_idx   = addr_q[MEM_AW-1:0];

    // Bits between the device ID and the word index must be zero so that a
    // smaller slave never aliases addresses that belong beyond its depth.
    generate
        if (GAP_W > 0) begin : g_gap
            assign range_ok = (addr_shift[BUS_AW-DEV_ID_W-1:MEM_AW] == '0);
        end else begin : g_nogap
            assign range_ok = 1'b1;
        end
    endgenerate

    assign match = id_ok && range_ok;

    // Phase sequencing and next values for every registered output.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q + 1'b1;
        addr_d   = addr_q;
        rw_d     = rw_q;
        shreg_d  = shreg_q;
        bus_in_d = 1'b0;
        ack_d    = ack_q;
        sbsy_d   = 1'b1;
        dvalid_d = 1'b0;
        dout_d   = dout_q;
        mem_we   = 1'b0;
        rd_en    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                cnt_d  = '0;
                sbsy_d = 1'b0;
                if (bus.AD_SEL) begin
                    state_d = ST_ADDR;
                    sbsy_d  = 1'b1;
                end
            end

            ST_ADDR: begin
                addr_d = addr_shift;
                if (cnt_q == ADDR_LAST) begin
                    cnt_d = '0;
                    rw_d  = bus.B_RW;
                    if (match) begin
                        state_d = ST_AACK;
                        ack_d   = 1'b1;
                    end else begin
                        state_d = ST_NACK;
                    end
                end
            end

            ST_AACK: begin
                if (cnt_q == ACK_LAST) begin
                    cnt_d   = '0;
                    ack_d   = 1'b0;
                    // Fetch now so the word is ready on the first data edge.
                    rd_en   = !rw_q;
                    state_d = rw_q ? ST_WDATA : ST_RDATA;
                end
            end

            ST_NACK: begin
                if (cnt_q == ACK_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_IDLE;
                    sbsy_d  = 1'b0;
                end
            end

            ST_WDATA: begin
                shreg_d = {bus.B_BUS_OUT, shreg_q[DATA_W-1:1]};
                if (cnt_q == WDATA_LAST) begin
                    cnt_d   = '0;
                    ack_d   = 1'b1;
                    state_d = ST_WACK;
                end
            end

            ST_WACK: begin
                if (cnt_q == ACK_LAST) begin
                    cnt_d    = '0;
                    ack_d    = 1'b0;
                    mem_we   = 1'b1;
                    dvalid_d = 1'b1;
                    dout_d   = shreg_q;
                    state_d  = ST_IDLE;
                    sbsy_d   = 1'b0;
                end
            end

            ST_RDATA: begin
                // The shifter rotates rather than shifts so that after DATA_W
                // bits it holds the original word again for S_DOUT.
                if (cnt_q == '0) begin
                    bus_in_d = rd_q[0];
                    shreg_d  = {rd_q[0], rd_q[DATA_W-1:1]};
                end else if (cnt_q == RDATA_LAST) begin
                    cnt_d    = '0;
                    dvalid_d = 1'b1;
                    dout_d   = shreg_q;
                    state_d  = ST_IDLE;
                    sbsy_d   = 1'b0;
                end else begin
                    bus_in_d = shreg_q[0];
                    shreg_d  = {shreg_q[0], shreg_q[DATA_W-1:1]};
                end
            end

            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                sbsy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            addr_q   <= '0;
            rw_q     <= 1'b0;
            shreg_q  <= '0;
            bus_in_q <= 1'b0;
            ack_q    <= 1'b0;
            sbsy_q   <= 1'b0;
            dvalid_q <= 1'b0;
            dout_q   <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            addr_q   <= addr_d;
            rw_q     <= rw_d;
            shreg_q  <= shreg_d;
            bus_in_q <= bus_in_d;
            ack_q    <= ack_d;
            sbsy_q   <= sbsy_d;
            dvalid_q <= dvalid_d;
            dout_q   <= dout_d;
        end
    end

    // Storage array, written only once the write acknowledge completes.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem[word_idx] <= shreg_q;
        end
    end

    // Registered read port giving one cycle of read latency.
    always_ff @(posedge CLK) begin
        if (rd_en) begin
            rd_q <= mem[word_idx];
        end
    end

    assign bus.B_BUS_IN = bus_in_q;
    assign bus.B_ACK    = ack_q;
    assign bus.B_SBSY   = sbsy_q;
    assign bus.S_DVALID = dvalid_q;
    assign bus.S_DOUT   = dout_q;

endmodule
